// File: rtl/blur_pixel_packer.sv
// blur_pixel_packer: packs four raster-order pixels into 32-bit words with SOF/EOF framing; PACKER_CHECKSUM_EN appends a frame checksum word
module blur_pixel_packer #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [7:0]  in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [31:0] out_din,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done
);
  localparam int WORDS = WIDTH * HEIGHT / 4;
  localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
`ifdef PACKER_CHECKSUM_EN
  typedef enum logic [1:0] {COLLECT, EMIT, CHECKSUM} state_t;
  logic [31:0] sum_q, sum_d;
`else
  typedef enum logic [1:0] {COLLECT, EMIT} state_t;
`endif
  state_t state_q, state_d;
  logic [1:0] lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  // state and datapath registers; reset discards any partial word and frame position
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      lane_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef PACKER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`ifdef PACKER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end
  // collect pixels into lanes, then emit the word; write-side outputs stay 0 unless writing
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
`ifdef PACKER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = '0;
    out_sof    = 1'b0;
    out_eof    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      COLLECT: if (!in_empty) begin
        in_rd_en = 1'b1;
        word_d[8*lane_q +: 8] = in_dout;
        lane_d = lane_q + 2'd1;
`ifdef PACKER_CHECKSUM_EN
        sum_d = sum_q + {24'd0, in_dout};
`endif
        state_d = lane_q == 2'd3 ? EMIT : COLLECT;
      end
      EMIT: if (!out_full) begin
        out_wr_en = 1'b1;
        out_din   = word_q;
        out_sof   = cnt_q == '0;
        cnt_d     = cnt_q == LAST ? '0 : cnt_q + CW'(1);
`ifdef PACKER_CHECKSUM_EN
        state_d   = cnt_q == LAST ? CHECKSUM : COLLECT;
`else
        out_eof    = cnt_q == LAST;
        frame_done = cnt_q == LAST;
        state_d    = COLLECT;
`endif
      end
`ifdef PACKER_CHECKSUM_EN
      CHECKSUM: if (!out_full) begin
        out_wr_en  = 1'b1;
        out_din    = sum_q;
        out_eof    = 1'b1;
        frame_done = 1'b1;
        sum_d      = '0;
        state_d    = COLLECT;
      end
`endif
      default: state_d = COLLECT;
    endcase
  end
endmodule
